// File: rtl/seq_pkg.sv
// Shared constants and enums for the 6-bit sequence generator/detector path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_pkg;

  localparam logic [5:0] PAT_A   = 6'b101101;
  localparam logic [5:0] PAT_B   = 6'b101001;
  localparam logic [5:0] PAT_ALT = 6'b101010;

  typedef enum logic [1:0] {
    SEL_A      = 2'd0,
    SEL_B      = 2'd1,
    SEL_CUSTOM = 2'd2,
    SEL_ALT    = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } gen_state_e;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, serial-out shift register, MSB first; load wins over shift.
// Latency: loaded word's MSB visible the cycle after load.
// Backpressure: none; holds its contents when neither enable is set.
module seq_piso_shift #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg;

  // Load a new word or shift left, zero-filling the vacated LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[W-2:0], 1'b0};
    end
  end

  assign msb = shreg[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a selected word out MSB-first, with repeats and gaps.
// Latency: first bit one cycle after accept; done pulses the cycle after the last bit.
// Backpressure: ready only in IDLE; start while busy is dropped, not queued.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 6,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       sel,
  input  logic [PAT_W-1:0] custom,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAT_W - 1);

  gen_state_e       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [PAT_W-1:0] pat_q;

  logic             accept;
  logic             frame_end;
  logic             reload;
  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sel_pat;
  logic [PAT_W-1:0] load_dat;
  logic             sr_msb;

  // Pattern chosen by the request inputs; only consumed at accept.
  always_comb begin
    sel_pat = PAT_W'(PAT_A);
    case (sel_e'(sel))
      SEL_A:      sel_pat = PAT_W'(PAT_A);
      SEL_B:      sel_pat = PAT_W'(PAT_B);
      SEL_CUSTOM: sel_pat = custom;
      SEL_ALT:    sel_pat = PAT_W'(PAT_ALT);
      default:    sel_pat = PAT_W'(PAT_A);
    endcase
  end

  assign accept    = start && (state == IDLE);
  assign frame_end = (state == SHIFT) && (bit_cnt == '0);
  // Reload either straight after a frame (no gap) or on the last gap cycle.
  assign reload    = (frame_end && (rep_cnt != '0) && (gap_q == '0)) ||
                     ((state == GAP) && (gap_cnt == '0));
  assign sr_load   = accept || reload;
  assign sr_shift  = (state == SHIFT) && !reload;
  assign load_dat  = accept ? sel_pat : pat_q;

  seq_piso_shift #(.W(PAT_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (load_dat),
    .msb   (sr_msb)
  );

  // Request FSM: frame bit counting, repeat and gap sequencing, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q   <= sel_pat;
            gap_q   <= gap;
            bit_cnt <= LAST_IDX;
            rep_cnt <= (reps == '0) ? '0 : reps - 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            if (rep_cnt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (gap_q == '0) begin
              bit_cnt <= LAST_IDX;
              rep_cnt <= rep_cnt - 1'b1;
            end else begin
              gap_cnt <= gap_q - 1'b1;
              state   <= GAP;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            bit_cnt <= LAST_IDX;
            rep_cnt <= rep_cnt - 1'b1;
            state   <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == SHIFT);
  assign out       = (state == SHIFT) && sr_msb;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen using a per-cycle expected-output queue.
// Latency: checks first bit at T+1 and done right after the last bit.
// Backpressure: exercises start while busy and accept in the done cycle.
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ready;
  logic [1:0] sel;
  logic [5:0] custom;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  // {out_valid, out, done, ready, busy}
  typedef logic [4:0] obs_t;
  obs_t sb[$];
  obs_t exp_v;
  obs_t obs_v;

  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_gen #(.PAT_W(6), .REP_W(4), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .sel       (sel),
    .custom    (custom),
    .reps      (reps),
    .gap       (gap),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] pat_of(input logic [1:0] s, input logic [5:0] c);
    case (s)
      2'd0:    pat_of = 6'b101101;
      2'd1:    pat_of = 6'b101001;
      2'd2:    pat_of = c;
      default: pat_of = 6'b101010;
    endcase
  endfunction

  // Push the expected cycles T+1 .. done for one request.
  task automatic push_req(input logic [1:0] s, input logic [5:0] c,
                          input logic [3:0] r, input logic [3:0] g);
    logic [5:0] p;
    int nf;
    p  = pat_of(s, c);
    nf = (r == 0) ? 1 : int'(r);
    for (int f = 0; f < nf; f++) begin
      for (int i = 5; i >= 0; i--) sb.push_back({1'b1, p[i], 1'b0, 1'b0, 1'b1});
      if (f < nf - 1)
        for (int k = 0; k < int'(g); k++) sb.push_back(5'b00001);
    end
    sb.push_back(5'b00110);
  endtask

  task automatic issue(input logic [1:0] s, input logic [5:0] c,
                       input logic [3:0] r, input logic [3:0] g);
    start  = 1'b1;
    sel    = s;
    custom = c;
    reps   = r;
    gap    = g;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    obs_v = {out_valid, out, done, ready, busy};
    n_cmp++;
    if (obs_v !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", obs_v, 5'b00010);
    end
    rst = 1'b0;
    @(negedge clk);
    obs_v = {out_valid, out, done, ready, busy};
    n_cmp++;
    if (obs_v !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", obs_v, 5'b00010);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    issue(2'd0, 6'h00, 4'd1, 4'd0);
    push_req(2'd0, 6'h00, 4'd1, 4'd0);
    sb.push_back(5'b00010);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL single T+%0d: got vld/out/done/rdy/busy=%b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_repeat_nogap();
    logic [5:0] win;
    int nvld;
    int hits;
    win = '0; nvld = 0; hits = 0;
    @(negedge clk);
    issue(2'd1, 6'h00, 4'd2, 4'd0);
    push_req(2'd1, 6'h00, 4'd2, 4'd0);
    sb.push_back(5'b00010);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      if (out_valid === 1'b1) begin
        win = {win[4:0], out};
        nvld++;
        if (nvld >= 6 && win == 6'b101001) hits++;
      end
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL repeat_nogap T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (hits !== 2) begin
      n_err++;
      $display("FAIL repeat_nogap_detect: got %0d hits want 2", hits);
    end
  endtask

  task automatic test_custom_gap();
    @(negedge clk);
    issue(2'd2, 6'b110011, 4'd3, 4'd2);
    push_req(2'd2, 6'b110011, 4'd3, 4'd2);
    sb.push_back(5'b00010);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      // Changing inputs after accept must have no effect.
      custom = 6'b000000;
      gap    = 4'd0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL custom_gap T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reps0_ignore_start();
    @(negedge clk);
    issue(2'd3, 6'h00, 4'd0, 4'd3);
    push_req(2'd3, 6'h00, 4'd0, 4'd3);
    sb.push_back(5'b00010);
    sb.push_back(5'b00010);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reps0_ignore T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (cyc == 2) issue(2'd0, 6'h00, 4'd1, 4'd0);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    issue(2'd0, 6'h00, 4'd1, 4'd0);
    sb.push_back(5'b11001);
    sb.push_back(5'b10001);
    sb.push_back(5'b11001);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL abort_pre T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs_v = {out_valid, out, done, ready, busy};
    n_cmp++;
    if (obs_v !== 5'b00010) begin
      n_err++;
      $display("FAIL abort_idle: got %b want %b", obs_v, 5'b00010);
    end
    issue(2'd2, 6'b011110, 4'd1, 4'd0);
    push_req(2'd2, 6'b011110, 4'd1, 4'd0);
    sb.push_back(5'b00010);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL abort_restart T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit second;
    second = 1'b0;
    @(negedge clk);
    issue(2'd0, 6'h00, 4'd1, 4'd0);
    push_req(2'd0, 6'h00, 4'd1, 4'd0);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (sb.size() == 0 && !second) begin
        second = 1'b1;
        issue(2'd1, 6'h00, 4'd2, 4'd1);
        push_req(2'd1, 6'h00, 4'd2, 4'd1);
        sb.push_back(5'b00010);
      end
    end
  endtask

  task automatic test_max_reps();
    int frames;
    frames = 0;
    @(negedge clk);
    issue(2'd3, 6'h00, 4'd15, 4'd1);
    push_req(2'd3, 6'h00, 4'd15, 4'd1);
    sb.push_back(5'b00010);
    for (int cyc = 1; sb.size() > 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front();
      obs_v = {out_valid, out, done, ready, busy};
      if (out_valid === 1'b1 && dut.bit_cnt == 3'd0) frames++;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL max_reps T+%0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (frames !== 15) begin
      n_err++;
      $display("FAIL max_reps_frames: got %0d want 15", frames);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 2'd0; custom = '0; reps = '0; gap = '0;
    test_reset();
    test_single();
    test_repeat_nogap();
    test_custom_gap();
    test_reps0_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_max_reps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
